uart_pack_parser: RTL and testbench

- Upstream neighbour of the UART register mapper.
- Consumes the byte stream from the UART receiver (one byte per rx_valid strobe) and frames fixed-length command packets.
- On a good frame it presents func_reg and rev_data1..rev_data11 together with a one-cycle pack_done, which the register mapper samples.
- Rejects malformed or stalled frames and counts them.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_pack_parser_if.sv | 46 ++++
 rtl/uart_byte_timeout.sv | 45 ++++
 rtl/uart_pack_parser.sv | 180 ++++++++++++++++++
 tb/tb_uart_pack_parser.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART command path (packet parser and register
// mapper): parser FSM state encoding, default sync bytes, payload length and
// the function codes understood by the register mapper.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StFunc,
      StData,
      StChk
   } state_e;

   localparam logic [7:0]  HDR0_DEF    = 8'h55;
   localparam logic [7:0]  HDR1_DEF    = 8'hAA;
   localparam int unsigned PAYLOAD_LEN = 11;

   localparam logic [7:0]  FUNC_HS_PWM = 8'h01;
   localparam logic [7:0]  FUNC_LS_PWM = 8'h02;

endpackage

// File: rtl/uart_pack_parser_if.sv
// ---------------------------------------------------------------------------
// uart_pack_parser_if
// Groups the byte stream from the UART receiver and the framed command
// outputs presented to the register mapper.
//   rx_data/rx_valid        : byte stream, one byte per single-cycle strobe
//   func_reg, rev_data1..11 : fields of the last good frame
//   pack_done               : one-cycle pulse, new good frame on the outputs
//   frame_err               : one-cycle pulse, frame discarded
//   err_cnt                 : saturating count of discarded frames
// Modports: master (byte source / frame consumer), slave (the parser).
// ---------------------------------------------------------------------------
interface uart_pack_parser_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] func_reg;
   logic [7:0] rev_data1;
   logic [7:0] rev_data2;
   logic [7:0] rev_data3;
   logic [7:0] rev_data4;
   logic [7:0] rev_data5;
   logic [7:0] rev_data6;
   logic [7:0] rev_data7;
   logic [7:0] rev_data8;
   logic [7:0] rev_data9;
   logic [7:0] rev_data10;
   logic [7:0] rev_data11;
   logic       pack_done;
   logic       frame_err;
   logic [7:0] err_cnt;

   modport master (
      output rx_data, rx_valid,
      input  func_reg, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5, rev_data6,
             rev_data7, rev_data8, rev_data9, rev_data10, rev_data11,
             pack_done, frame_err, err_cnt
   );

   modport slave (
      input  rx_data, rx_valid,
      output func_reg, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5, rev_data6,
             rev_data7, rev_data8, rev_data9, rev_data10, rev_data11,
             pack_done, frame_err, err_cnt
   );

endinterface

// File: rtl/uart_byte_timeout.sv
// ---------------------------------------------------------------------------
// uart_byte_timeout
// Inter-byte idle counter. Clears whenever clr is high, otherwise counts up
// while en is high and stops at the terminal count (never wraps).
//   clk_50M : system clock
//   rst_n   : asynchronous active-low reset
//   clr     : clear counter to 0 (priority over en)
//   en      : count enable
//   tc      : counter is at _TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module uart_byte_timeout #(
   parameter int unsigned _TIMEOUT_CYC = 50000,
   parameter int unsigned _TO_WIDTH    = 16
) (
   input  logic clk_50M,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [_TO_WIDTH-1:0] TermCnt = _TO_WIDTH'(_TIMEOUT_CYC - 1);

   logic [_TO_WIDTH-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == TermCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_pack_parser.sv
// ---------------------------------------------------------------------------
// uart_pack_parser
// Frames fixed-length command packets from the UART byte stream:
//   _HDR0 _HDR1 FUNC D1..D11 [CHK]
// A good frame is committed to func_reg/rev_data1..11 with a one-cycle
// pack_done; bad checksums and inter-byte stalls give a one-cycle frame_err
// and bump the saturating err_cnt.
// Ports:
//   clk_50M : 50 MHz system clock
//   rst_n   : asynchronous active-low reset
//   bus     : uart_pack_parser_if.slave (byte stream in, frame fields out)
// Build option: define UART_PACK_CHK_EN to expect and verify the trailing
// CHK byte (sum of FUNC..D11 mod 256). Without it the frame ends at D11 and
// frame_err comes only from the inter-byte timeout.
// ---------------------------------------------------------------------------
module uart_pack_parser
   import uart_pkg::*;
#(
   parameter logic [7:0]  _HDR0        = HDR0_DEF,
   parameter logic [7:0]  _HDR1        = HDR1_DEF,
   parameter int unsigned _TIMEOUT_CYC = 50000,
   parameter int unsigned _TO_WIDTH    = 16
) (
   input logic               clk_50M,
   input logic               rst_n,
   uart_pack_parser_if.slave bus
);

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] func_sh_q, func_sh_d;
   logic [7:0] data_sh_q [1:PAYLOAD_LEN];
   logic [7:0] data_sh_d [1:PAYLOAD_LEN];
`ifdef UART_PACK_CHK_EN
   logic [7:0] sum_q, sum_d;
`endif

   logic       commit, err, tc;
   logic [7:0] func_q;
   logic [7:0] rev_q [1:PAYLOAD_LEN];
   logic       pack_done_q, frame_err_q;
   logic [7:0] err_cnt_q;

   // Counter runs only while a frame is in progress.
   uart_byte_timeout #(
      ._TIMEOUT_CYC(_TIMEOUT_CYC),
      ._TO_WIDTH   (_TO_WIDTH)
   ) u_timeout (
      .clk_50M(clk_50M),
      .rst_n  (rst_n),
      .clr    (bus.rx_valid | (state_q == StIdle)),
      .en     (1'b1),
      .tc     (tc)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      func_sh_d = func_sh_q;
      data_sh_d = data_sh_q;
`ifdef UART_PACK_CHK_EN
      sum_d     = sum_q;
`endif
      commit    = 1'b0;
      err       = 1'b0;

      // A byte arriving in the terminal-count cycle takes priority over the timeout.
      if (bus.rx_valid) begin
         unique case (state_q)
            StIdle: begin
               if (bus.rx_data == _HDR0) state_d = StSync;
            end
            StSync: begin
               if (bus.rx_data == _HDR1) begin
                  state_d = StFunc;
               end else if (bus.rx_data != _HDR0) begin
                  state_d = StIdle;
               end
            end
            StFunc: begin
               func_sh_d = bus.rx_data;
`ifdef UART_PACK_CHK_EN
               sum_d     = bus.rx_data;
`endif
               idx_d     = 4'd1;
               state_d   = StData;
            end
            StData: begin
               data_sh_d[idx_q] = bus.rx_data;
`ifdef UART_PACK_CHK_EN
               sum_d            = sum_q + bus.rx_data;
`endif
               if (idx_q == 4'(PAYLOAD_LEN)) begin
`ifdef UART_PACK_CHK_EN
                  state_d = StChk;
`else
                  commit  = 1'b1;
                  state_d = StIdle;
`endif
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
`ifdef UART_PACK_CHK_EN
            StChk: begin
               if (bus.rx_data == sum_q) begin
                  commit = 1'b1;
               end else begin
                  err = 1'b1;
               end
               state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
         endcase
      end else if (tc && (state_q != StIdle)) begin
         err     = 1'b1;
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         func_sh_q <= '0;
         data_sh_q <= '{default: '0};
`ifdef UART_PACK_CHK_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         func_sh_q <= func_sh_d;
         data_sh_q <= data_sh_d;
`ifdef UART_PACK_CHK_EN
         sum_q     <= sum_d;
`endif
      end
   end

   // Commit from the next-state shadows so the final byte is included
   // whether the frame ends on D11 or on CHK.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         func_q      <= '0;
         rev_q       <= '{default: '0};
         pack_done_q <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         pack_done_q <= commit;
         frame_err_q <= err;
         if (commit) begin
            func_q <= func_sh_d;
            rev_q  <= data_sh_d;
         end
         if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign bus.func_reg   = func_q;
   assign bus.rev_data1  = rev_q[1];
   assign bus.rev_data2  = rev_q[2];
   assign bus.rev_data3  = rev_q[3];
   assign bus.rev_data4  = rev_q[4];
   assign bus.rev_data5  = rev_q[5];
   assign bus.rev_data6  = rev_q[6];
   assign bus.rev_data7  = rev_q[7];
   assign bus.rev_data8  = rev_q[8];
   assign bus.rev_data9  = rev_q[9];
   assign bus.rev_data10 = rev_q[10];
   assign bus.rev_data11 = rev_q[11];
   assign bus.pack_done  = pack_done_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_pack_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_pack_parser
// Directed bench for uart_pack_parser: table of byte sequences with
// hand-computed results, plus sequences for stall timeout, err_cnt
// saturation and reset mid-frame. Expectations follow UART_PACK_CHK_EN.
// ---------------------------------------------------------------------------
module tb_uart_pack_parser;

`ifdef UART_PACK_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef struct {
      logic [0:15][7:0] b;
      int               len;
      bit               is_frame;  // last byte is CHK (dropped from framing if CHK disabled)
      logic             exp_done;
      logic             exp_err;
      logic [7:0]       func, d1, d2, d3, d5, d8;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   uart_pack_parser_if bus ();

   uart_pack_parser dut (
      .clk_50M(clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   err_seen = 0;
   bit   both_seen = 1'b0;
   logic [7:0] exp_err_cnt = 8'd0;
   vec_t vecs [4];

   always @(negedge clk) begin
      if (bus.pack_done) done_seen++;
      if (bus.frame_err) err_seen++;
      if (bus.pack_done && bus.frame_err) both_seen = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      #1;
   endtask

   task automatic bump_err();
      if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
   endtask

   task automatic run_vec(input int vi);
      int done0, err0, last;
      vec_t v;
      v     = vecs[vi];
      done0 = done_seen;
      err0  = err_seen;
      last  = (v.is_frame && !CHK_EN) ? v.len - 2 : v.len - 1;
      for (int i = 0; i < v.len; i++) begin
         send_byte(v.b[i]);
         if (i == last) begin
            check($sformatf("v%0d pack_done_latency", vi), 32'(bus.pack_done), 32'(v.exp_done));
            check($sformatf("v%0d frame_err_latency", vi), 32'(bus.frame_err), 32'(v.exp_err));
         end
      end
      repeat (3) @(negedge clk);
      #1;
      if (v.exp_err) bump_err();
      check($sformatf("v%0d done_pulses", vi), 32'(done_seen - done0), 32'(v.exp_done));
      check($sformatf("v%0d err_pulses", vi), 32'(err_seen - err0), 32'(v.exp_err));
      check($sformatf("v%0d func_reg", vi), 32'(bus.func_reg), 32'(v.func));
      check($sformatf("v%0d rev_data1", vi), 32'(bus.rev_data1), 32'(v.d1));
      check($sformatf("v%0d rev_data2", vi), 32'(bus.rev_data2), 32'(v.d2));
      check($sformatf("v%0d rev_data3", vi), 32'(bus.rev_data3), 32'(v.d3));
      check($sformatf("v%0d rev_data5", vi), 32'(bus.rev_data5), 32'(v.d5));
      check($sformatf("v%0d rev_data8", vi), 32'(bus.rev_data8), 32'(v.d8));
      check($sformatf("v%0d err_cnt", vi), 32'(bus.err_cnt), 32'(exp_err_cnt));
   endtask

   task automatic check_all_zero(input string tag);
      logic [7:0] any_data;
      any_data = bus.rev_data1 | bus.rev_data2 | bus.rev_data3 | bus.rev_data4 |
                 bus.rev_data5 | bus.rev_data6 | bus.rev_data7 | bus.rev_data8 |
                 bus.rev_data9 | bus.rev_data10 | bus.rev_data11;
      check({tag, " func_reg"}, 32'(bus.func_reg), 32'h0);
      check({tag, " rev_data_any"}, 32'(any_data), 32'h0);
      check({tag, " pack_done"}, 32'(bus.pack_done), 32'h0);
      check({tag, " frame_err"}, 32'(bus.frame_err), 32'h0);
      check({tag, " err_cnt"}, 32'(bus.err_cnt), 32'h0);
   endtask

   initial begin
      int k, d0, e0;

      // FUNC=01 D1..D11 = 02 01 0A 00 32 05 00 FF FF FF 00 -> sum 0x342, CHK 0x42
      vecs[0].b = {8'h55, 8'hAA, 8'h01, 8'h02, 8'h01, 8'h0A, 8'h00, 8'h32,
                   8'h05, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h42, 8'h00};
      vecs[0].len = 15; vecs[0].is_frame = 1'b1;
      vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0;
      vecs[0].func = 8'h01; vecs[0].d1 = 8'h02; vecs[0].d2 = 8'h01;
      vecs[0].d3 = 8'h0A; vecs[0].d5 = 8'h32; vecs[0].d8 = 8'hFF;
      // Same payload, wrong CHK: rejected only when CHK is checked
      vecs[1] = vecs[0];
      vecs[1].b[14] = 8'h43;
      vecs[1].exp_done = !CHK_EN; vecs[1].exp_err = CHK_EN;
      // Resync 55 55 AA, FUNC=02, D1=03, rest 0, CHK=05
      vecs[2].b = {8'h55, 8'h55, 8'hAA, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
      vecs[2].len = 16; vecs[2].is_frame = 1'b1;
      vecs[2].exp_done = 1'b1; vecs[2].exp_err = 1'b0;
      vecs[2].func = 8'h02; vecs[2].d1 = 8'h03; vecs[2].d2 = 8'h00;
      vecs[2].d3 = 8'h00; vecs[2].d5 = 8'h00; vecs[2].d8 = 8'h00;
      // Noise and aborted sync: silently ignored, outputs hold vector 2 values
      vecs[3] = vecs[2];
      vecs[3].b = '0;
      vecs[3].b[0] = 8'h12; vecs[3].b[1] = 8'h34; vecs[3].b[2] = 8'h55; vecs[3].b[3] = 8'h13;
      vecs[3].len = 4; vecs[3].is_frame = 1'b0;
      vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b0;

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int vi = 0; vi < 4; vi++) run_vec(vi);

      // Stall after 55 AA 01 02
      send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
      k = 0;
      while (!bus.frame_err && k < 50100) begin
         @(negedge clk);
         k++;
      end
      check("timeout_cycle_in_window", 32'(k >= 49998 && k <= 50001), 32'h1);
      bump_err();
      @(negedge clk);
      #1;
      check("timeout_pulse_single", 32'(bus.frame_err), 32'h0);
      check("timeout_err_cnt", 32'(bus.err_cnt), 32'(exp_err_cnt));
      check("timeout_outputs_hold", 32'(bus.func_reg), 32'h02);
      run_vec(0);

      // Many bad-checksum frames
      d0 = done_seen;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < vecs[1].len; i++) send_byte(vecs[1].b[i]);
         if (CHK_EN) bump_err();
      end
      repeat (3) @(negedge clk);
      #1;
      check("sat_err_cnt", 32'(bus.err_cnt), 32'(exp_err_cnt));
      check("sat_done_pulses", 32'(done_seen - d0), CHK_EN ? 32'd0 : 32'd300);

      // Reset mid-frame
      send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
      d0 = done_seen;
      e0 = err_seen;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_err_cnt = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("midreset_no_done", 32'(done_seen - d0), 32'd0);
      check("midreset_no_err", 32'(err_seen - e0), 32'd0);
      run_vec(2);

      check("done_err_exclusive", 32'(both_seen), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
